md_sched: RTL and testbench

//   Sequences the shared multiply/divide resource (HI/LO) for the 5-stage pipeline.

---
 rtl/md_pkg.sv | 26 ++
 rtl/md_arith.sv | 77 +++++++
 rtl/md_sched.sv | 135 +++++++++++++
 tb/tb_md_sched.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// md_pkg
//   Shared definitions for the multiply/divide scheduler: MD opcode encoding,
//   the IDLE/BUSY state type and the latency counter width.
//   Optional feature macro: MD_MADD_EN enables the madd/maddu/msub/msubu opcodes.
package md_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MADD  = 4'd7;
    localparam logic [3:0] MD_MADDU = 4'd8;
    localparam logic [3:0] MD_MSUB  = 4'd9;
    localparam logic [3:0] MD_MSUBU = 4'd10;

    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/md_arith.sv
// md_arith
//   Combinational datapath of the multiply/divide unit. Given the latched op and
//   operands plus the current HI/LO, produces the HI/LO values to commit.
//   Ports:
//     op       in  4   latched MD opcode
//     rs, rt   in  32  latched operands
//     hi, lo   in  32  current architectural HI/LO (hold value and accumulator)
//     hi_next  out 32  HI value to commit
//     lo_next  out 32  LO value to commit
//   Optional feature macro: MD_MADD_EN adds the multiply-accumulate family.
module md_arith
    import md_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] hi_next,
    output logic [31:0] lo_next
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               div_ovf;
    logic signed [31:0] rt_s_safe;
    logic        [31:0] rt_u_safe;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;

    assign prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
    assign prod_u = {32'h0, rs} * {32'h0, rt};

    // The divider is never fed a zero divisor or the INT_MIN / -1 pair; those
    // cases are resolved by the mux below, so the raw quotient is don't-care.
    assign div_ovf   = (rs == 32'h8000_0000) && (rt == 32'hFFFF_FFFF);
    assign rt_s_safe = (rt == 32'h0 || div_ovf) ? 32'sd1 : $signed(rt);
    assign rt_u_safe = (rt == 32'h0) ? 32'd1 : rt;
    assign quot_s    = $signed(rs) / rt_s_safe;
    assign rem_s     = $signed(rs) % rt_s_safe;

    // Defaults hold HI/LO, which also covers divide by zero.
    always_comb begin
        hi_next = hi;
        lo_next = lo;
        case (op)
            MD_MULT:  {hi_next, lo_next} = prod_s;
            MD_MULTU: {hi_next, lo_next} = prod_u;
            MD_DIV: begin
                if (rt != 32'h0) begin
                    if (div_ovf) begin
                        lo_next = 32'h8000_0000;
                        hi_next = 32'h0;
                    end else begin
                        lo_next = quot_s;
                        hi_next = rem_s;
                    end
                end
            end
            MD_DIVU: begin
                if (rt != 32'h0) begin
                    lo_next = rs / rt_u_safe;
                    hi_next = rs % rt_u_safe;
                end
            end
`ifdef MD_MADD_EN
            MD_MADD:  {hi_next, lo_next} = {hi, lo} + prod_s;
            MD_MADDU: {hi_next, lo_next} = {hi, lo} + prod_u;
            MD_MSUB:  {hi_next, lo_next} = {hi, lo} - prod_s;
            MD_MSUBU: {hi_next, lo_next} = {hi, lo} - prod_u;
`endif
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// md_sched
//   Sequences the shared multiply/divide unit for the 5-stage pipeline, owns the
//   architectural HI/LO registers and raises a stall request to the hazard unit.
//   Ports:
//     clk     in  1   rising-edge clock
//     reset   in  1   synchronous active-low reset
//     start   in  1   EX-stage MD instruction valid (one-cycle pulse)
//     op      in  4   MD opcode (md_pkg encoding)
//     rsVal   in  32  forwarded rs operand
//     rtVal   in  32  forwarded rt operand
//     dIsMd   in  1   D-stage instruction touches the MD unit
//     busy    out 1   unit occupied (registered)
//     stall   out 1   dIsMd & (start | busy), combinational
//     hi, lo  out 32  architectural HI/LO (registered)
//   Optional feature macro: MD_MADD_EN enables madd/maddu/msub/msubu.
module md_sched
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rsVal,
    input  logic [31:0] rtVal,
    input  logic        dIsMd,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

    md_state_t        state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [3:0]       op_q;
    logic [31:0]      rs_q, rt_q;
    logic             load, commit, wr_hi, wr_lo;
    logic             is_mul, is_div;
    logic [31:0]      hi_next, lo_next;

    always_comb begin
        is_mul = (op == MD_MULT) || (op == MD_MULTU);
`ifdef MD_MADD_EN
        is_mul = is_mul || (op == MD_MADD) || (op == MD_MADDU) ||
                 (op == MD_MSUB) || (op == MD_MSUBU);
`endif
        is_div = (op == MD_DIV) || (op == MD_DIVU);
    end

    md_arith u_arith (
        .op      (op_q),
        .rs      (rs_q),
        .rt      (rt_q),
        .hi      (hi),
        .lo      (lo),
        .hi_next (hi_next),
        .lo_next (lo_next)
    );

    // Next-state logic: starts are honoured only in IDLE; in BUSY the counter
    // runs down and the edge that sees it at 1 commits the result.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        load       = 1'b0;
        commit     = 1'b0;
        wr_hi      = 1'b0;
        wr_lo      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (is_mul) begin
                        load       = 1'b1;
                        cnt_next   = MULT_N;
                        state_next = BUSY;
                    end else if (is_div) begin
                        load       = 1'b1;
                        cnt_next   = DIV_N;
                        state_next = BUSY;
                    end else if (op == MD_MTHI) begin
                        wr_hi = 1'b1;
                    end else if (op == MD_MTLO) begin
                        wr_lo = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (cnt == CNT_W'(1)) begin
                    commit     = 1'b1;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= MD_NONE;
            rs_q  <= '0;
            rt_q  <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (load) begin
                op_q <= op;
                rs_q <= rsVal;
                rt_q <= rtVal;
            end
            if (commit) begin
                hi <= hi_next;
                lo <= lo_next;
            end else begin
                if (wr_hi) hi <= rsVal;
                if (wr_lo) lo <= rsVal;
            end
        end
    end

    assign busy  = (state == BUSY);
    assign stall = dIsMd & (start | busy);

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched
//   Bench for md_sched: directed scenarios with hand-computed expectations plus a
//   randomized phase, all compared every cycle against a reference model that
//   tracks remaining busy cycles and computes HI/LO with plain arithmetic.
//   Optional feature macro: MD_MADD_EN (must match the RTL build).
module tb_md_sched;
    import md_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] rsVal = 32'h0;
    logic [31:0] rtVal = 32'h0;
    logic        dIsMd = 1'b0;
    logic        busy, stall;
    logic [31:0] hi, lo;

    always #5 clk = ~clk;

    md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .rsVal (rsVal),
        .rtVal (rtVal),
        .dIsMd (dIsMd),
        .busy  (busy),
        .stall (stall),
        .hi    (hi),
        .lo    (lo)
    );

    int checks = 0;
    int passed = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference model: remaining busy cycles plus the pending operation.
    logic [31:0] mHi = 32'h0, mLo = 32'h0;
    int          mLeft = 0;
    logic [3:0]  mOp = 4'd0;
    logic [31:0] mRs = 32'h0, mRt = 32'h0;
    bit          cmpEn = 1'b0;

    function automatic bit isMulClass(input logic [3:0] o);
`ifdef MD_MADD_EN
        return (o == 4'd1) || (o == 4'd2) || (o >= 4'd7 && o <= 4'd10);
`else
        return (o == 4'd1) || (o == 4'd2);
`endif
    endfunction

    function automatic logic [63:0] mdResult(input logic [3:0] o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] h,
                                             input logic [31:0] l);
        logic [63:0] acc, ps, pu;
        logic [31:0] ma, mb, q, r;
        longint sa, sb;
        acc = {h, l};
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ps  = sa * sb;
        pu  = {32'h0, a} * {32'h0, b};
        case (o)
            4'd1: return ps;
            4'd2: return pu;
            4'd3: begin
                if (b == 32'h0) return acc;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                ma = a[31] ? -a : a;
                mb = b[31] ? -b : b;
                q  = ma / mb;
                r  = ma % mb;
                if (a[31] ^ b[31]) q = -q;
                if (a[31]) r = -r;
                return {r, q};
            end
            4'd4: begin
                if (b == 32'h0) return acc;
                return {a % b, a / b};
            end
`ifdef MD_MADD_EN
            4'd7:  return acc + ps;
            4'd8:  return acc + pu;
            4'd9:  return acc - ps;
            4'd10: return acc - pu;
`endif
            default: return acc;
        endcase
    endfunction

    // Model advances on the same edge as the DUT, from the same sampled inputs.
    always @(posedge clk) begin
        if (!reset) begin
            mHi = 32'h0;
            mLo = 32'h0;
            mLeft = 0;
        end else if (mLeft > 0) begin
            mLeft--;
            if (mLeft == 0) {mHi, mLo} = mdResult(mOp, mRs, mRt, mHi, mLo);
        end else if (start) begin
            if (isMulClass(op) || op == 4'd3 || op == 4'd4) begin
                mLeft = isMulClass(op) ? MC : DC;
                mOp = op;
                mRs = rsVal;
                mRt = rtVal;
            end else if (op == 4'd5) begin
                mHi = rsVal;
            end else if (op == 4'd6) begin
                mLo = rsVal;
            end
        end
    end

    // Every-cycle comparison, sampled mid-cycle.
    always @(negedge clk) begin
        if (cmpEn) begin
            checkOutput("busy", 32'(busy), 32'(mLeft > 0));
            checkOutput("stall", 32'(stall), 32'(dIsMd & (start | (mLeft > 0))));
            checkOutput("hi", hi, mHi);
            checkOutput("lo", lo, mLo);
        end
    end

    // Drives a one-cycle start pulse; called and returns at 1 time unit after a posedge.
    task automatic applyStimulus(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o;
        rsVal = a;
        rtVal = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 4'd0;
    endtask

    task automatic waitIdle(output int n);
        bit done;
        n = 0;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) begin
                done = 1'b1;
                break;
            end
            n++;
            @(posedge clk);
            #1;
        end
        if (!done) checkOutput("wait_bound", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not end, required finish");
        $fatal(1, "[TB] timeout");
    end

    int n;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        cmpEn = 1'b1;
        @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_hi", hi, 32'h0);
        checkOutput("rst_lo", lo, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // mult -1 * 2
        applyStimulus(MD_MULT, 32'hFFFF_FFFF, 32'd2);
        waitIdle(n);
        checkOutput("t1_busy_cycles", n, 32'd5);
        checkOutput("t1_hi", hi, 32'hFFFF_FFFF);
        checkOutput("t1_lo", lo, 32'hFFFF_FFFE);

        // divu and signed div
        applyStimulus(MD_DIVU, 32'd7, 32'd2);
        waitIdle(n);
        checkOutput("t2_divu_cycles", n, 32'd10);
        checkOutput("t2_divu_hi", hi, 32'd1);
        checkOutput("t2_divu_lo", lo, 32'd3);
        applyStimulus(MD_DIV, -32'sd7, 32'd2);
        waitIdle(n);
        checkOutput("t2_div_hi", hi, 32'hFFFF_FFFF);
        checkOutput("t2_div_lo", lo, 32'hFFFF_FFFD);
        applyStimulus(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        waitIdle(n);
        checkOutput("t2_ovf_hi", hi, 32'h0);
        checkOutput("t2_ovf_lo", lo, 32'h8000_0000);

        // divide by zero holds HI/LO
        applyStimulus(MD_MTHI, 32'hA, 32'h0);
        applyStimulus(MD_MTLO, 32'hB, 32'h0);
        checkOutput("t3_mthi", hi, 32'hA);
        checkOutput("t3_mtlo", lo, 32'hB);
        applyStimulus(MD_DIV, 32'd5, 32'd0);
        waitIdle(n);
        checkOutput("t3_busy_cycles", n, 32'd10);
        checkOutput("t3_hi", hi, 32'hA);
        checkOutput("t3_lo", lo, 32'hB);

        // stall and mid-busy start ignored
        op = MD_MULT;
        rsVal = 32'd3;
        rtVal = 32'd4;
        start = 1'b1;
        dIsMd = 1'b1;
        @(negedge clk);
        checkOutput("t4_stall_start", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("t4_stall_busy", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(MD_MTLO, 32'h1234, 32'h0);
        waitIdle(n);
        checkOutput("t4_stall_idle", 32'(stall), 32'd0);
        checkOutput("t4_hi", hi, 32'h0);
        checkOutput("t4_lo", lo, 32'd12);
        dIsMd = 1'b0;

        // reset mid-divide abandons the op
        applyStimulus(MD_MTHI, 32'h55, 32'h0);
        applyStimulus(MD_DIV, 32'd100, 32'd3);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t5_busy", 32'(busy), 32'd0);
        checkOutput("t5_hi", hi, 32'h0);
        checkOutput("t5_lo", lo, 32'h0);
        repeat (12) @(posedge clk);
        #1;
        checkOutput("t5_late_hi", hi, 32'h0);
        checkOutput("t5_late_lo", lo, 32'h0);

        // multiply-accumulate
        applyStimulus(MD_MTHI, 32'h0, 32'h0);
        applyStimulus(MD_MTLO, 32'hFFFF_FFFF, 32'h0);
        applyStimulus(MD_MADD, 32'd1, 32'd1);
        waitIdle(n);
`ifdef MD_MADD_EN
        checkOutput("t6_cycles", n, 32'd5);
        checkOutput("t6_hi", hi, 32'h1);
        checkOutput("t6_lo", lo, 32'h0);
`else
        checkOutput("t6_cycles", n, 32'd0);
        checkOutput("t6_hi", hi, 32'h0);
        checkOutput("t6_lo", lo, 32'hFFFF_FFFF);
`endif

        // randomized phase
        for (int i = 0; i < 1500; i++) begin
            start = ($urandom_range(0, 3) == 0);
            op    = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: rsVal = $urandom_range(0, 50);
                1: rsVal = $urandom;
                2: rsVal = 32'h8000_0000;
                default: rsVal = 32'hFFFF_FFFF;
            endcase
            case ($urandom_range(0, 4))
                0: rtVal = 32'h0;
                1: rtVal = $urandom_range(1, 9);
                2: rtVal = 32'hFFFF_FFFF;
                default: rtVal = $urandom;
            endcase
            dIsMd = $urandom_range(0, 1) == 1;
            reset = ($urandom_range(0, 199) != 0);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        op = 4'd0;
        dIsMd = 1'b0;
        reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        cmpEn = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
